// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM sample writer slice.
// The QAM_WR_STATS_EN build option is handled in qam_axi_sample_writer.sv.
package qam_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         SAMPLE_W      = 64;

    function automatic int beat_bytes(input int data_w);
        return data_w / 8;
    endfunction

    localparam int BEAT_BYTES = SAMPLE_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/qam_sync_fifo.sv
// Synchronous FIFO with a registered head stage: an entry written into storage becomes
// visible on o_head (o_head_vld) one clock later, giving a fixed two-cycle push-to-pop path.
module qam_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_head_vld,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_mem_cnt;
    logic             r_head_vld;
    logic [WIDTH-1:0] r_head;

    logic             w_load;
    logic [AW:0]      w_total;

    // Refill the head register whenever it is free or being consumed this cycle.
    assign w_load  = (r_mem_cnt != '0) && (!r_head_vld || i_pop);
    assign w_total = r_mem_cnt + {{AW{1'b0}}, r_head_vld};

    assign o_full     = (w_total == (AW+1)'(DEPTH));
    assign o_empty    = (w_total == '0);
    assign o_head_vld = r_head_vld;
    assign o_head     = r_head;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_head_vld <= 1'b0;
            r_head     <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_head   <= r_mem[r_rd_ptr];
            end
            r_mem_cnt <= r_mem_cnt + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, w_load};
            if (w_load) begin
                r_head_vld <= 1'b1;
            end else if (i_pop) begin
                r_head_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/qam_axi_sample_writer.sv
// Buffers QAM samples and writes each as a single-beat AXI4 write into a circular region.
// Define QAM_WR_STATS_EN to implement the overflow and error counters (otherwise tied to 0).
module qam_axi_sample_writer
    import qam_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                BUF_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     sample_in,
    input  logic                  sample_valid,
    output logic [ADDR_W-1:0]     S_AXI_AWADDR,
    output logic                  S_AXI_AWVALID,
    input  logic                  S_AXI_AWREADY,
    output logic [DATA_W-1:0]     S_AXI_WDATA,
    output logic [DATA_W/8-1:0]   S_AXI_WSTRB,
    output logic                  S_AXI_WVALID,
    input  logic                  S_AXI_WREADY,
    input  logic                  S_AXI_BVALID,
    input  logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BREADY,
    output logic                  busy,
    output logic [15:0]           ovf_cnt,
    output logic [15:0]           err_cnt
);

    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(beat_bytes(DATA_W));
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'((BUF_WORDS - 1) * beat_bytes(DATA_W));

    // Handshakes: a VALID, once raised, holds with stable payload until the cycle its READY is seen.
    wr_state_t          r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0]  r_awaddr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;

    logic               w_full;
    logic               w_empty;
    logic               w_head_vld;
    logic [DATA_W-1:0]  w_head;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_aw_acc;
    logic               w_w_acc;

    assign w_pop    = (r_state == IDLE) && w_head_vld;
    assign w_push   = sample_valid && (!w_full || w_pop);
    assign w_drop   = sample_valid && w_full && !w_pop;
    // Accept flags: the channel has completed earlier or completes on this edge.
    assign w_aw_acc = !r_awvalid || S_AXI_AWREADY;
    assign w_w_acc  = !r_wvalid || S_AXI_WREADY;

    qam_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_push),
        .i_data     (sample_in),
        .i_pop      (w_pop),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head_vld (w_head_vld),
        .o_head     (w_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_ptr     <= BASE_ADDR;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_head_vld) begin
                        r_wdata   <= w_head;
                        r_awaddr  <= r_ptr;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= XFER;
                    end
                end
                XFER: begin
                    if (S_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (S_AXI_WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_acc && w_w_acc) begin
                        r_bready <= 1'b1;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    // Errored beats are not retried; the pointer advances either way.
                    if (S_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        r_ptr    <= (r_ptr == LAST_ADDR) ? BASE_ADDR : r_ptr + STEP;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign S_AXI_AWADDR  = r_awaddr;
    assign S_AXI_AWVALID = r_awvalid;
    assign S_AXI_WDATA   = r_wdata;
    assign S_AXI_WSTRB   = '1;
    assign S_AXI_WVALID  = r_wvalid;
    assign S_AXI_BREADY  = r_bready;
    assign busy          = !w_empty || (r_state != IDLE);

`ifdef QAM_WR_STATS_EN
    logic [15:0] r_ovf_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
            if ((r_state == RESP) && S_AXI_BVALID && (S_AXI_BRESP != AXI_RESP_OKAY)
                && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign ovf_cnt = r_ovf_cnt;
    assign err_cnt = r_err_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_drop ^ (^S_AXI_BRESP);
    assign ovf_cnt        = '0;
    assign err_cnt        = '0;
`endif

endmodule
